// File: rtl/spi_adc_responder.sv
// MCP3002-compatible SPI responder: decodes the start/SGL/ODD/MSBF command and
// streams a 10-bit result taken from two parallel sample inputs.
module spi_adc_responder #(
   parameter int DATA_W      = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic              adc_cs,
   input  logic              adc_sck,
   input  logic              sdata_to_adc,
   output logic              sdata_from_adc,
   output logic              dout_oe,
   input  logic [DATA_W-1:0] sample_ch0,
   input  logic [DATA_W-1:0] sample_ch1,
   output logic              cmd_valid,
   output logic              cmd_sgl,
   output logic              cmd_odd,
   output logic              cmd_msbf,
   output logic              frame_error,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DATA_W);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_START, S_CMD, S_NULL, S_DATA, S_TRAIL
   } state_t;

   logic [SYNC_STAGES-1:0] cs_sync, sck_sync, din_sync;
   logic                   cs_d, sck_d;
   logic                   cs_s, sck_s, din_s;
   logic                   cs_rise, cs_fall, sck_rise, sck_fall;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               sgl_t, sgl_t_n, odd_t, odd_t_n;
   logic [DATA_W-1:0]  result, result_n, result_sel;
   logic [DATA_W:0]    diff_01, diff_10;
   logic               dout_n, oe_n, busy_n;
   logic               cmd_valid_n, cmd_sgl_n, cmd_odd_n, cmd_msbf_n, frame_error_n;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         cs_sync  <= '1;
         sck_sync <= '0;
         din_sync <= '0;
         cs_d     <= 1'b1;
         sck_d    <= 1'b0;
      end else begin
         cs_sync  <= {cs_sync[SYNC_STAGES-2:0], adc_cs};
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], adc_sck};
         din_sync <= {din_sync[SYNC_STAGES-2:0], sdata_to_adc};
         cs_d     <= cs_sync[SYNC_STAGES-1];
         sck_d    <= sck_sync[SYNC_STAGES-1];
      end
   end

   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign din_s    = din_sync[SYNC_STAGES-1];
   assign cs_rise  = cs_s & ~cs_d;
   assign cs_fall  = ~cs_s & cs_d;
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;

   // Differential results are formed one bit wider so a borrow clamps to zero.
   assign diff_01 = {1'b0, sample_ch0} - {1'b0, sample_ch1};
   assign diff_10 = {1'b0, sample_ch1} - {1'b0, sample_ch0};

   always_comb begin
      result_sel = sample_ch0;
      if (sgl_t)      result_sel = odd_t ? sample_ch1 : sample_ch0;
      else if (odd_t) result_sel = diff_10[DATA_W] ? '0 : diff_10[DATA_W-1:0];
      else            result_sel = diff_01[DATA_W] ? '0 : diff_01[DATA_W-1:0];
   end

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         cnt            <= '0;
         sgl_t          <= 1'b0;
         odd_t          <= 1'b0;
         result         <= '0;
         sdata_from_adc <= 1'b0;
         dout_oe        <= 1'b0;
         busy           <= 1'b0;
         cmd_valid      <= 1'b0;
         cmd_sgl        <= 1'b0;
         cmd_odd        <= 1'b0;
         cmd_msbf       <= 1'b0;
         frame_error    <= 1'b0;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         sgl_t          <= sgl_t_n;
         odd_t          <= odd_t_n;
         result         <= result_n;
         sdata_from_adc <= dout_n;
         dout_oe        <= oe_n;
         busy           <= busy_n;
         cmd_valid      <= cmd_valid_n;
         cmd_sgl        <= cmd_sgl_n;
         cmd_odd        <= cmd_odd_n;
         cmd_msbf       <= cmd_msbf_n;
         frame_error    <= frame_error_n;
      end
   end

   // NOTE: every variable gets its default first so no path through the case infers a latch.
   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      sgl_t_n       = sgl_t;
      odd_t_n       = odd_t;
      result_n      = result;
      dout_n        = sdata_from_adc;
      oe_n          = dout_oe;
      busy_n        = busy;
      cmd_valid_n   = 1'b0;
      cmd_sgl_n     = cmd_sgl;
      cmd_odd_n     = cmd_odd;
      cmd_msbf_n    = cmd_msbf;
      frame_error_n = 1'b0;

      if (cs_rise) begin
         state_n       = S_IDLE;
         oe_n          = 1'b0;
         dout_n        = 1'b0;
         busy_n        = 1'b0;
         frame_error_n = state inside {S_CMD, S_NULL, S_DATA};
      end else begin
         case (state)
            S_IDLE: if (cs_fall) state_n = S_WAIT_START;
            S_WAIT_START: if (sck_rise && din_s) begin
               state_n = S_CMD;
               busy_n  = 1'b1;
               cnt_n   = '0;
            end
            S_CMD: if (sck_rise) begin
               cnt_n = cnt + CNT_ONE;
               if (cnt == '0)          sgl_t_n = din_s;
               else if (cnt == CNT_ONE) odd_t_n = din_s;
               else begin
                  cmd_valid_n = 1'b1;
                  cmd_sgl_n   = sgl_t;
                  cmd_odd_n   = odd_t;
                  cmd_msbf_n  = din_s;
                  result_n    = result_sel;
                  state_n     = S_NULL;
               end
            end
            S_NULL: if (sck_fall) begin
               if (!dout_oe) begin
                  oe_n   = 1'b1;
                  dout_n = 1'b0;
               end else begin
                  state_n = S_DATA;
                  dout_n  = result[DATA_W-1];
                  cnt_n   = CNT_TOP;
               end
            end
            S_DATA: if (sck_fall) begin
               if (cnt == '0) begin
                  // D0 is shared between the MSB-first and LSB-first halves.
                  state_n = S_TRAIL;
                  dout_n  = ~cmd_msbf & result[1];
                  cnt_n   = CNT_TWO;
               end else begin
                  dout_n = result[cnt - CNT_ONE];
                  cnt_n  = cnt - CNT_ONE;
               end
            end
            S_TRAIL: if (sck_fall) begin
               if (!cmd_msbf && cnt < CNT_END) begin
                  dout_n = result[cnt];
                  cnt_n  = cnt + CNT_ONE;
               end else begin
                  dout_n = 1'b0;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: an SPI mode-0 master at 2 MHz records
// DOUT just before each SCK fall and compares against hand-computed words.
module tb_spi_adc_responder;

   localparam int DATA_W      = 10;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 250;  // ns, SCK = 2 MHz

   logic              sysclk = 1'b0;
   logic              rst_n, cs, sck, din;
   logic              dout, oe, cv, sgl, odd, msbf, fe, busy;
   logic [DATA_W-1:0] ch0, ch1;

   int checks   = 0;
   int failures = 0;
   int cv_cnt   = 0;
   int fe_cnt   = 0;

   logic samp    [0:63];
   logic samp_oe [0:63];

   spi_adc_responder #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
      .sysclk         (sysclk),
      .rst_n          (rst_n),
      .adc_cs         (cs),
      .adc_sck        (sck),
      .sdata_to_adc   (din),
      .sdata_from_adc (dout),
      .dout_oe        (oe),
      .sample_ch0     (ch0),
      .sample_ch1     (ch1),
      .cmd_valid      (cv),
      .cmd_sgl        (sgl),
      .cmd_odd        (odd),
      .cmd_msbf       (msbf),
      .frame_error    (fe),
      .busy           (busy)
   );

   always #10 sysclk = ~sysclk;

   always @(posedge sysclk) begin
      if (cv === 1'b1) cv_cnt++;
      if (fe === 1'b1) fe_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Gathers n recorded DOUT samples, first sample ends up as the MSB.
   function automatic logic [31:0] bits(input int start, input int n);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v = {v[30:0], samp[start + i]};
      return v;
   endfunction

   // One frame of nper SCK periods; cmd holds ncmd leading DIN bits, MSB first.
   // With coinc set, CS falls at the same instant as the first SCK rise.
   task automatic frame(input int nper, input bit coinc, input logic [15:0] cmd, input int ncmd);
      @(posedge sysclk);
      #5;
      if (!coinc) begin
         cs = 1'b0;
         #HALF;
      end
      for (int i = 0; i < nper; i++) begin
         din = (i < ncmd) ? cmd[ncmd - 1 - i] : 1'b0;
         #HALF;
         if (i == 0) cs = 1'b0;
         sck = 1'b1;
         #HALF;
         samp[i]    = dout;
         samp_oe[i] = oe;
         sck = 1'b0;
      end
      din = 1'b0;
      #HALF;
      samp[nper]    = dout;
      samp_oe[nper] = oe;
      cs = 1'b1;
   endtask

   task automatic settle();
      repeat (10) @(posedge sysclk);
      #1;
   endtask

   // Standard 16-period MCP3002 frame, command {start, sgl, odd, msbf}.
   task automatic std_frame(input string tag, input logic [3:0] cmd, input logic [DATA_W-1:0] exp);
      int cv0, fe0;
      cv0 = cv_cnt;
      fe0 = fe_cnt;
      frame(16, 1'b0, {12'h000, cmd}, 4);
      settle();
      check({tag, "_oe_pre"}, samp_oe[3], 1'b0);
      check({tag, "_seq"},    bits(4, 11), {21'h0, 1'b0, exp});
      check({tag, "_cv"},     cv_cnt - cv0, 1);
      check({tag, "_flags"},  {sgl, odd, msbf}, cmd[2:0]);
      check({tag, "_no_fe"},  fe_cnt - fe0, 0);
      check({tag, "_idle"},   {oe, busy, dout}, 3'b000);
   endtask

   initial begin
      int cv0, fe0;
      rst_n = 1'b0;
      cs    = 1'b0;
      sck   = 1'b0;
      din   = 1'b0;
      ch0   = '0;
      ch1   = '0;

      // Reset with CS low and SCK toggling.
      repeat (3) begin
         @(negedge sysclk);
         sck = ~sck;
      end
      @(posedge sysclk);
      #1;
      check("reset_outputs", {dout, oe, cv, sgl, odd, msbf, fe, busy}, 8'h00);
      cs  = 1'b1;
      sck = 1'b0;
      repeat (2) @(posedge sysclk);
      #5;
      rst_n = 1'b1;
      settle();
      check("reset_idle", {oe, busy, fe}, 3'b000);

      // CH0 single-ended, MSB first; trailing bits must be zero.
      ch0 = 10'h2A5;
      ch1 = 10'h155;
      std_frame("ch0_msbf", 4'b1101, 10'h2A5);
      check("ch0_trail_zero", bits(15, 2), 0);

      ch1 = 10'h3FF;
      std_frame("ch1", 4'b1111, 10'h3FF);

      ch0 = 10'h100;
      ch1 = 10'h180;
      std_frame("diff_10", 4'b1011, 10'h080);
      std_frame("diff_01_sat", 4'b1001, 10'h000);

      // LSB-first repeat of D1..D9 after D0.
      ch0 = 10'h2A5;
      ch1 = 10'h000;
      frame(26, 1'b0, 16'b1100, 4);
      settle();
      check("lsbf_seq",   bits(4, 11), 11'h2A5);
      check("lsbf_trail", bits(15, 9), 9'h095);
      check("lsbf_zeros", bits(24, 3), 0);

      // Leading zeros before the start bit.
      ch0 = 10'h001;
      ch1 = 10'h3FF;
      cv0 = cv_cnt;
      fe0 = fe_cnt;
      frame(24, 1'b0, 16'b001100, 6);
      settle();
      check("lead_cv",      cv_cnt - cv0, 1);
      check("lead_oe_pre",  samp_oe[5], 1'b0);
      check("lead_seq",     bits(6, 11), 11'h001);
      check("lead_trail",   bits(17, 8), 0);
      check("lead_oe_end",  samp_oe[24], 1'b1);
      check("lead_no_fe",   fe_cnt - fe0, 0);
      check("lead_oe_off",  oe, 1'b0);

      // Abort after D9..D5 have been driven.
      ch0 = 10'h2A5;
      fe0 = fe_cnt;
      frame(9, 1'b0, 16'b1101, 4);
      repeat (SYNC_STAGES + 2) @(posedge sysclk);
      #1;
      check("abort_oe_busy", {oe, busy}, 2'b00);
      settle();
      check("abort_fe",   fe_cnt - fe0, 1);
      check("abort_bits", bits(4, 5), 5'b01010);

      ch1 = 10'h0F0;
      std_frame("after_abort", 4'b1111, 10'h0F0);

      // CS fall coincident with an SCK rise: that rise's DIN=1 must be ignored.
      ch0 = 10'h155;
      ch1 = 10'h0AA;
      cv0 = cv_cnt;
      frame(17, 1'b1, 16'b11101, 5);
      settle();
      check("coinc_cv",    cv_cnt - cv0, 1);
      check("coinc_flags", {sgl, odd, msbf}, 3'b101);
      check("coinc_seq",   bits(5, 11), 11'h155);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_adc_responder.md
Name: spi_adc_responder

Overview:
- Bit-accurate SPI responder that emulates the MCP3002 10-bit ADC as seen from its SPI pins.
- Driven by the existing MCP3002 SPI master, or by an external master, through the signals adc_cs, adc_sck and sdata_to_adc; it returns sdata_from_adc.
- Conversion values come from two parallel sample inputs. Used for on-chip loopback, hardware-in-loop test and FPGA-to-FPGA links.
- All SPI inputs are oversampled by sysclk (50 MHz); SCK is at most 2 MHz.

Parameters:
- DATA_W, 10, conversion width (bits per result).
- SYNC_STAGES, 2, synchroniser flops on adc_cs, adc_sck and sdata_to_adc (minimum 2).

Ports:
- sysclk  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous active-low reset
- adc_cs  in  1  chip select from master, active low
- adc_sck  in  1  SPI clock from master
- sdata_to_adc  in  1  command bits from master (DIN)
- sdata_from_adc  out  1  result bits to master (DOUT)
- dout_oe  out  1  1 = DOUT is driven; 0 = DOUT is high-Z at the pad wrapper
- sample_ch0  in  DATA_W  analogue value for CH0
- sample_ch1  in  DATA_W  analogue value for CH1
- cmd_valid  out  1  one-cycle pulse when the MSBF bit is captured
- cmd_sgl  out  1  captured SGL bit
- cmd_odd  out  1  captured ODD/SIGN (channel) bit
- cmd_msbf  out  1  captured MSBF bit
- frame_error  out  1  one-cycle pulse when CS rises mid-frame
- busy  out  1  high from start-bit capture until CS rises

Behaviour:
- Reset (rst_n=0 at a sysclk rising edge) clears everything:
  - sdata_from_adc=0, dout_oe=0, cmd_valid=0, cmd_sgl=0, cmd_odd=0, cmd_msbf=0, frame_error=0, busy=0.
  - FSM goes to IDLE; synchronisers are cleared to cs=1, sck=0, din=0.
  - Reset mid-frame abandons the frame silently (no frame_error).
- Input handling: the three SPI inputs pass through SYNC_STAGES flops. Rise and fall of sck, and fall and rise of cs, are detected by comparing the last two synchronised values. Detection latency is SYNC_STAGES+1 sysclk from the pin edge.
- The master samples DOUT near SCK fall. DOUT therefore changes only on detected SCK falls and holds through the next fall.
- FSM states: IDLE, WAIT_START, CMD, NULL, DATA, TRAIL.
  - IDLE: cs=1. On cs fall -> WAIT_START.
  - WAIT_START: on each sck rise, if din=1 -> CMD (busy=1, bit count=0); if din=0, stay (leading zeros are legal).
  - CMD: sck rises 1, 2 and 3 capture SGL, ODD and MSBF in that order.
    - At the third rise, pulse cmd_valid and latch the result.
    - SGL=1: result = ODD ? sample_ch1 : sample_ch0.
    - SGL=0, ODD=0: result = ch0 - ch1, saturating at 0.
    - SGL=0, ODD=1: result = ch1 - ch0, saturating at 0.
    - Subtraction uses DATA_W+1 bits; a negative result gives 0.
    - Then -> NULL.
  - NULL: at the next sck fall, drive dout_oe=1 and sdata_from_adc=0 (null bit). At the following sck fall -> DATA and drive D[DATA_W-1].
  - DATA: each sck fall drives the next lower bit. D0 is driven on fall DATA_W+1 after the null bit. At the next sck fall -> TRAIL.
  - TRAIL:
    - MSBF=1: drive 0 indefinitely.
    - MSBF=0: drive D1, D2, … D[DATA_W-1] on successive falls (LSB-first repeat), then 0 indefinitely.
    - Further din bits are ignored.
- cs rise in any state -> IDLE next cycle, with dout_oe=0, sdata_from_adc=0 and busy=0.
  - frame_error pulses for 1 cycle if the rise occurs in CMD, NULL or DATA before D0 has been driven for a full SCK fall-to-fall period.
  - No error in WAIT_START or TRAIL.
- cs fall and sck edge detected in the same cycle: cs is processed first; that sck edge is ignored.
- sample_ch0/1 may change at any time; only the value present at the capture cycle is used.
- cmd_sgl, cmd_odd and cmd_msbf hold until the next cmd_valid or reset.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with cs=0 and sck toggling -> all outputs 0; FSM in IDLE afterwards.
- MCP3002 master loopback: sample_ch0=10'h2A5, command start,1,0,1 -> cmd_valid pulse with sgl=1, odd=0, msbf=1; DOUT after fall sequence 0,1,0,1,0,1,0,0,1,0,1; master data_from_adc=10'h2A5.
- Channel 1 and differential: sample_ch1=10'h3FF, SGL=1, ODD=1 -> 10'h3FF. Then sample_ch0=10'h100, sample_ch1=10'h180, SGL=0:
  - ODD=1 -> 10'h080.
  - ODD=0 -> 10'h000 (saturated).
- Leading zeros and LSB-first: din 0,0,1,1,0,0 with sample_ch0=10'h001; run 24 SCK periods -> null bit, 0000000001, then repeat bits D1..D9 = all 0; dout_oe=1 until cs rises.
- Abort: cs rises after D9..D5 are driven -> frame_error pulses for one cycle, dout_oe=0 and busy=0 within SYNC_STAGES+2 cycles. The next frame is captured correctly.
- Timing margin: master at SCK=2 MHz, and a frame with the cs fall coincident with an sck rise -> no bit slip; sampled result equals the sample input.
